// File: rtl/mult_pipe_sched_pkg.sv
// Shared configuration for the multiplier-pipeline scheduler.
// Holds the default widths and latencies. Every file of this block imports it.
package mult_pipe_sched_pkg;

    localparam int unsigned DefDataWidth = 160;
    localparam int unsigned DefNDigital  = 16;
    localparam int unsigned DefPipeLat   = 11;
    localparam int unsigned DefResDepth  = 16;

    // The b operand carries one extra digit on top of the field width.
    function automatic int unsigned calc_bwidth(input int unsigned dw, input int unsigned nd);
        return (dw / nd + 1) * nd;
    endfunction

endpackage

// File: rtl/mult_pipe_sched_result_fifo.sv
// result_fifo: synchronous FIFO that buffers captured multiplier results.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (clears pointers and count)
//   push, push_data    write request and data
//   pop                read request; ignored when empty
//   pop_data           head entry, valid whenever empty is low
//   empty, count       status
// A push while full is accepted only when a pop happens in the same cycle.
module result_fifo
    import mult_pipe_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DefDataWidth + 1,
    parameter int unsigned DEPTH = DefResDepth
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             full, do_push, do_pop;

    // Explicit wrap so that non-power-of-two depths also work.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/mult_pipe_sched.sv
// mult_pipe_sched: arbitrates two requesters onto a fixed-latency GF(2^m)
// multiplier pipeline and collects the results in issue order.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         per-requester handshake (ready = grant)
//   req{0,1}_{a,b,g}            operands of each requester
//   pl_a, pl_b, pl_g            operands driven into the external pipeline
//   pl_t                        pipeline result, PIPE_LAT cycles after sampling
//   res_valid/res_ready         result handshake
//   res_data, res_id            result and index of the issuing requester
//   inflight                    ops issued but not yet captured
// The pipeline shares one field polynomial among all ops in flight, so a
// requester with a different g waits until the pipeline is empty.
// PIPE_LAT must be at least 2.
module mult_pipe_sched
    import mult_pipe_sched_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DefDataWidth,
    parameter  int unsigned N_DIGITAL  = DefNDigital,
    parameter  int unsigned PIPE_LAT   = DefPipeLat,
    parameter  int unsigned RES_DEPTH  = DefResDepth,
    localparam int unsigned BWIDTH     = calc_bwidth(DATA_WIDTH, N_DIGITAL),
    localparam int unsigned IFW        = $clog2(PIPE_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [BWIDTH-1:0]     req0_b,
    input  logic [BWIDTH-1:0]     req1_b,
    input  logic [DATA_WIDTH-1:0] req0_g,
    input  logic [DATA_WIDTH-1:0] req1_g,
    output logic [DATA_WIDTH-1:0] pl_a,
    output logic [BWIDTH-1:0]     pl_b,
    output logic [DATA_WIDTH-1:0] pl_g,
    input  logic [DATA_WIDTH-1:0] pl_t,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_id,
    output logic [IFW-1:0]        inflight
);

    localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

    logic [PIPE_LAT-1:0]   sr_valid_q, sr_id_q;
    logic [IFW-1:0]        inflight_q;
    logic                  ptr_q;
    logic [DATA_WIDTH-1:0] cur_g_q;

    logic [1:0]            eligible, grant;
    logic                  room, issue, capture, fifo_empty;
    logic [CntW-1:0]       fifo_count;
    logic [DATA_WIDTH:0]   fifo_out;

    // A different g is only acceptable once nothing is left in the pipeline.
    assign eligible[0] = req_valid[0] && ((req0_g == cur_g_q) || (inflight_q == '0));
    assign eligible[1] = req_valid[1] && ((req1_g == cur_g_q) || (inflight_q == '0));

    // Reserve a buffer slot for every op in flight; no credit for a same-cycle pop.
    assign room = (32'(inflight_q) + 32'(fifo_count)) < RES_DEPTH;

    // A valid but ineligible priority requester blocks the other one, which
    // forces the pipeline to drain and keeps the g switch from starving.
    always_comb begin
        grant = '0;
        if (rst_n && room) begin
            if (eligible[ptr_q]) begin
                grant[ptr_q] = 1'b1;
            end else if (!req_valid[ptr_q] && eligible[~ptr_q]) begin
                grant[~ptr_q] = 1'b1;
            end
        end
    end

    assign issue     = |grant;
    assign req_ready = grant;
    assign capture   = sr_valid_q[PIPE_LAT-1];

    always_comb begin
        pl_a = '0;
        pl_b = '0;
        pl_g = rst_n ? cur_g_q : '0;
        if (grant[0]) begin
            pl_a = req0_a;
            pl_b = req0_b;
            pl_g = req0_g;
        end else if (grant[1]) begin
            pl_a = req1_a;
            pl_b = req1_b;
            pl_g = req1_g;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_valid_q <= '0;
            sr_id_q    <= '0;
            inflight_q <= '0;
            ptr_q      <= 1'b0;
            cur_g_q    <= '0;
        end else begin
            sr_valid_q <= {sr_valid_q[PIPE_LAT-2:0], issue};
            sr_id_q    <= {sr_id_q[PIPE_LAT-2:0], grant[1]};
            if (issue && !capture) begin
                inflight_q <= inflight_q + IFW'(1);
            end else if (!issue && capture) begin
                inflight_q <= inflight_q - IFW'(1);
            end
            if (issue) begin
                ptr_q   <= grant[0];
                cur_g_q <= pl_g;
            end
        end
    end

    assign res_valid = rst_n && !fifo_empty;

    result_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data ({sr_id_q[PIPE_LAT-1], pl_t}),
        .pop       (res_valid && res_ready),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_data = fifo_out[DATA_WIDTH-1:0];
    assign res_id   = fifo_out[DATA_WIDTH];
    assign inflight = inflight_q;

endmodule

// File: tb/tb_mult_pipe_sched.sv
// Directed bench for mult_pipe_sched with a behavioural GF(2^160) pipeline.
module tb_mult_pipe_sched;

    localparam int unsigned DW = 160;
    localparam int unsigned BW = 176;
    localparam int unsigned PL = 11;

    localparam logic [DW-1:0] G1 = 160'h25;
    localparam logic [DW-1:0] G2 = 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0047;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_ready;
    logic [DW-1:0] req0_a, req1_a, req0_g, req1_g;
    logic [BW-1:0] req0_b, req1_b;
    logic [DW-1:0] pl_a, pl_g, pl_t, res_data;
    logic [BW-1:0] pl_b;
    logic          res_valid, res_ready, res_id;
    logic [3:0]    inflight;

    int            n_total = 0;
    int            n_bad   = 0;
    int            n0 = 0, n1 = 0;
    logic [DW-1:0] g0, g1;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] pipe_q [PL];

    mult_pipe_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req1_a    (req1_a),
        .req0_b    (req0_b),
        .req1_b    (req1_b),
        .req0_g    (req0_g),
        .req1_g    (req1_g),
        .pl_a      (pl_a),
        .pl_b      (pl_b),
        .pl_g      (pl_g),
        .pl_t      (pl_t),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    // Multiply a by b (MSB first) modulo x^160 + g.
    function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a, input logic [BW-1:0] b,
                                             input logic [DW-1:0] g);
        logic [DW-1:0] t;
        logic          c;
        t = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            c = t[DW-1];
            t = t << 1;
            if (c) t = t ^ g;
            if (b[i]) t = t ^ a;
        end
        return t;
    endfunction

    function automatic logic [DW-1:0] op_a(input int i, input int n);
        return {32'hC0DE_0000 | 32'(n), 32'(i) ^ 32'h5A5A_5A5A, 96'h0123_4567_89AB_CDEF_F00D_BEEF};
    endfunction

    function automatic logic [BW-1:0] op_b(input int i, input int n);
        return {16'(n + 1), 32'(i) + 32'h1111_2222, 128'hFEDC_BA98_7654_3210_0F0F_F0F0_1234_5678};
    endfunction

    // Stand-in for the external multiplier: PL-cycle latency.
    always @(posedge clk) begin
        pipe_q[0] <= (pl_b == '0) ? '0 : gf_mul(pl_a, pl_b, pl_g);
        for (int i = 1; i < PL; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign pl_t = pipe_q[PL-1];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Result scoreboard: every accepted result must match the head of exp_q.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("res_unexpected", 256'(res_valid), 256'd0);
            end else begin
                check_eq("res", 256'({res_id, res_data}), 256'(exp_q.pop_front()));
            end
        end
    end

    task automatic settle();
        req0_a = op_a(0, n0);
        req0_b = op_b(0, n0);
        req0_g = g0;
        req1_a = op_a(1, n1);
        req1_b = op_b(1, n1);
        req1_g = g1;
        #1;
    endtask

    // Check the grant of this cycle, record expected results, advance to next cycle.
    task automatic cyc(input string tag, input logic [1:0] exp_gnt);
        check_eq(tag, 256'(req_ready), 256'(exp_gnt));
        if (exp_gnt[0]) begin
            exp_q.push_back({1'b0, gf_mul(op_a(0, n0), op_b(0, n0), g0)});
            n0++;
        end
        if (exp_gnt[1]) begin
            exp_q.push_back({1'b1, gf_mul(op_a(1, n1), op_b(1, n1), g1)});
            n1++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #2;
        end
        check_eq(tag, 256'(exp_q.size()), 256'd0);
    endtask

    int lat;

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        res_ready = 1'b1;
        g0        = G1;
        g1        = G1;
        @(posedge clk);
        #2;

        // Reset: no grant, quiet pipeline inputs, no result.
        settle();
        check_eq("rst_pl_a", 256'(pl_a), 256'd0);
        check_eq("rst_pl_g", 256'(pl_g), 256'd0);
        check_eq("rst_res_valid", 256'(res_valid), 256'd0);
        check_eq("rst_inflight", 256'(inflight), 256'd0);
        cyc("rst_gnt", 2'b00);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        settle();
        check_eq("post_rst_pl_g", 256'(pl_g), 256'd0);
        check_eq("post_rst_res_valid", 256'(res_valid), 256'd0);
        cyc("post_rst_gnt", 2'b00);

        // Single op 1*1 from requester 0: result 1 appears 12 cycles after issue.
        req_valid = 2'b01;
        req0_a    = 160'h1;
        req0_b    = 176'h1;
        req0_g    = G1;
        #1;
        check_eq("t1_gnt", 256'(req_ready), 256'b01);
        check_eq("t1_pl_a", 256'(pl_a), 256'h1);
        check_eq("t1_pl_g", 256'(pl_g), 256'(G1));
        exp_q.push_back({1'b0, 160'h1});
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        #1;
        check_eq("t1_inflight", 256'(inflight), 256'd1);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            if (res_valid) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #3;
        end
        check_eq("t1_latency", 256'(lat), 256'd12);
        @(posedge clk);
        #2;
        wait_drain("t1_drain");

        // Both requesters, same g: alternate starting at requester 1.
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            settle();
            cyc("t2_alt", (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        req_valid = 2'b00;
        wait_drain("t2_drain");

        // Requester 0 streams G1; requester 1 with G2 at the pointer forces a drain.
        req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            settle();
            cyc("t3_stream", 2'b01);
        end
        req_valid = 2'b11;
        g1        = G2;
        for (int k = 0; k < 11; k++) begin
            settle();
            check_eq("t3_hold_pl_g", 256'(pl_g), 256'(G1));
            cyc("t3_stall", 2'b00);
        end
        settle();
        check_eq("t3_switch_pl_g", 256'(pl_g), 256'(G2));
        cyc("t3_switch", 2'b10);
        req_valid = 2'b00;
        wait_drain("t3_drain");

        // Backpressure: exactly RES_DEPTH issues, then hold until released.
        g0        = G2;
        res_ready = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 16; k++) begin
            settle();
            cyc("t4_fill", (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        for (int k = 0; k < 14; k++) begin
            settle();
            cyc("t4_full", 2'b00);
        end
        check_eq("t4_full_valid", 256'(res_valid), 256'd1);
        req_valid = 2'b00;
        res_ready = 1'b1;
        wait_drain("t4_drain");

        // Push and pop in the same cycle with 15 buffered.
        res_ready = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 15; k++) begin
            settle();
            cyc("t5_fill", 2'b01);
        end
        req_valid = 2'b00;
        for (int k = 0; k < 12; k++) begin
            settle();
            cyc("t5_wait", 2'b00);
        end
        req_valid = 2'b01;
        settle();
        cyc("t5_issue", 2'b01);
        req_valid = 2'b00;
        for (int k = 0; k < 10; k++) begin
            settle();
            cyc("t5_fly", 2'b00);
        end
        res_ready = 1'b1;
        settle();
        check_eq("t5_inflight_cap", 256'(inflight), 256'd1);
        cyc("t5_pushpop", 2'b00);
        res_ready = 1'b0;
        req_valid = 2'b01;
        settle();
        cyc("t5_room15", 2'b01);
        settle();
        cyc("t5_room16", 2'b00);
        req_valid = 2'b00;
        res_ready = 1'b1;
        wait_drain("t5_drain");

        // Reset with 5 ops in flight and 3 buffered; nothing may survive it.
        res_ready = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            settle();
            cyc("t6_issue", 2'b01);
        end
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++) begin
            settle();
            cyc("t6_wait", 2'b00);
        end
        settle();
        check_eq("t6_pre_inflight", 256'(inflight), 256'd5);
        check_eq("t6_pre_valid", 256'(res_valid), 256'd1);
        exp_q.delete();
        rst_n     = 1'b0;
        req_valid = 2'b01;
        settle();
        check_eq("t6_rst_pl_a", 256'(pl_a), 256'd0);
        check_eq("t6_rst_pl_g", 256'(pl_g), 256'd0);
        check_eq("t6_rst_valid", 256'(res_valid), 256'd0);
        cyc("t6_rst_gnt", 2'b00);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        res_ready = 1'b1;
        settle();
        check_eq("t6_post_inflight", 256'(inflight), 256'd0);
        for (int k = 0; k < 20; k++) begin
            settle();
            check_eq("t6_no_stale", 256'(res_valid), 256'd0);
            cyc("t6_idle", 2'b00);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_pipe_sched.md
MULT_PIPE_SCHED -- requirements
Module: mult_pipe_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 160: operand width a, g, result; bit width of each.
REQ-002 Parameter N_DIGITAL, default 16: digit width; BWIDTH = (DATA_WIDTH/N_DIGITAL + 1)*N_DIGITAL = 176.
REQ-003 Parameter PIPE_LAT, default 11: cycles from a multiplier-input sample edge until its result is valid at the multiplier output.
REQ-004 Parameter RES_DEPTH, default 16: result buffer depth; must be at least PIPE_LAT+1.
REQ-005 The block has one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 req_valid[1:0]  in  2  per-requester request valid.
REQ-009 req_ready[1:0]  out  2  per-requester accept; transfer when valid&ready.
REQ-010 req0_a, req1_a  in  DATA_WIDTH  multiplicand per requester.
REQ-011 req0_b, req1_b  in  BWIDTH  digit-serial multiplier operand; top digit consumed first.
REQ-012 req0_g, req1_g  in  DATA_WIDTH  field polynomial per requester.
REQ-013 pl_a  out  DATA_WIDTH  to pipeline a; granted a on issue, else 0.
REQ-014 pl_b  out  BWIDTH  to pipeline b; granted b on issue, else 0.
REQ-015 pl_g  out  DATA_WIDTH  to pipeline g; granted g on issue, else cur_g.
REQ-016 pl_t  in  DATA_WIDTH  pipeline result t_i_j_out.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  result consumer accept.
REQ-019 res_data  out  DATA_WIDTH  result.
REQ-020 res_id  out  1  requester index that issued the result.
REQ-021 inflight  out  $clog2(PIPE_LAT+1)  ops issued but not yet captured.

Function
REQ-022 Issue = combinational grant in cycle k; pipeline samples pl_* at end of cycle k; result captured from pl_t at end of cycle k+PIPE_LAT.
REQ-023 A 1+1-bit valid/id shift register of PIPE_LAT stages tracks issues; bubbles shall never be captured.
REQ-024 cur_g register holds the g of the most recent issue; pl_g shall equal cur_g whenever nothing issues, so g never changes with ops in flight.
REQ-025 Requester i is eligible when req_valid[i] and (reqi_g == cur_g or inflight == 0).
REQ-026 Issue is allowed only when inflight + fifo_count < RES_DEPTH, using current-cycle registered counts (no same-cycle pop bypass).
REQ-027 Round-robin: priority pointer starts at 0; after a grant to i the pointer becomes 1-i.
REQ-028 If the priority requester is eligible and issue is allowed, it is granted; else if the priority requester is not valid, the other eligible requester is granted.
REQ-029 Drain rule: if the priority requester is valid but ineligible (g mismatch), no grant in that cycle; pipeline drains until inflight == 0, guaranteeing no starvation.
REQ-030 At most one grant per cycle; req_ready[i] = grant[i]; ready may depend on valid, never the reverse.
REQ-031 inflight increments on issue, decrements on capture, unchanged when both occur.
REQ-032 Captured {pl_t, id} enter result_fifo; res_valid = fifo not empty; pop on res_valid&res_ready; simultaneous push and pop at full or empty shall be lossless.
REQ-033 Results leave in issue order; throughput one op per cycle when same g and res_ready=1.

Reset
REQ-034 On rst_n=0 at a rising edge: valid/id shift register, inflight, fifo pointers and count, pointer, cur_g cleared to 0.
REQ-035 During reset and the following cycle: res_valid=0, req_ready=0 while rst_n=0, pl_a=pl_b=0, pl_g=0.
REQ-036 Reset mid-operation discards all in-flight and buffered results; none shall appear after reset.

Structure
REQ-037 DATA_WIDTH, N_DIGITAL, PIPE_LAT, RES_DEPTH defaults belong in the shared configuration include.
REQ-038 One sub-module, result_fifo (synchronous, width DATA_WIDTH+1, depth RES_DEPTH, count output).

Verification
REQ-039 req0 a=1, b=1, g=G1 issued cycle k -> res_valid at cycle k+12 after capture, res_data equals the golden GF(2^160) model, res_id=0.
REQ-040 Both requesters valid continuously, same g -> grants alternate 0,1,0,1, one issue per cycle, results in order with matching ids.
REQ-041 req0 streaming g=G1, req1 g=G2 at pointer -> no issue until inflight=0 (≤11 cycles), then req1 issues with pl_g=G2.
REQ-042 res_ready=0, both streaming -> exactly 16 issues, then req_ready=0; release -> 16 correct results, no loss or duplication.
REQ-043 rst_n low one cycle with 5 ops in flight and 3 buffered -> res_valid=0 and inflight=0 after reset; no stale result for 20 cycles.
REQ-044 Issue and pop in the same cycle with count 15 -> count stays 15, data intact.
